// File: rtl/divisor_pkg.sv
// divisor_pkg: shared constants and state encoding for the sequential divider.
//   DIV_WIDTH  default divisor/quotient/remainder width (dividend is 2*DIV_WIDTH)
//   DIV_CNT_W  step counter width for the default width, clog2(DIV_WIDTH+1)
//   state_e    FSM state encoding (IDLE, CALC, DONE)
package divisor_pkg;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/divisor_step.sv
// divisor_step: one combinational restoring-division iteration.
//   i_r        partial remainder (always < divisor, so WIDTH bits suffice)
//   i_q        dividend/quotient shift register
//   i_divisor  divisor
//   o_r_c      next partial remainder
//   o_q_c      next shift register, new quotient bit shifted in at the LSB
module divisor_step
    import divisor_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_r_c,
    output logic [WIDTH-1:0] o_q_c
);

    logic [WIDTH:0] w_t;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // Shift the next dividend bit into the remainder, trial-subtract the divisor.
    always_comb begin
        w_t    = {i_r, i_q[WIDTH-1]};
        w_diff = w_t - {1'b0, i_divisor};
        w_ge   = (w_t >= {1'b0, i_divisor});
        // After a successful subtract the result is < divisor, so the MSB is zero.
        o_r_c  = w_ge ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
        o_q_c  = {i_q[WIDTH-2:0], w_ge};
    end

endmodule

// File: rtl/divisor.sv
// divisor: sequential unsigned restoring divider, one quotient bit per clock,
// with the St/Idle/Done handshake shared with the shift-add multiplier.
//   Clk, Rst_n        clock (rising edge), asynchronous active-low reset
//   St                start, accepted only while Idle=1
//   Dividendo         2*WIDTH-bit dividend, sampled with St
//   Divisor           WIDTH-bit divisor, sampled with St
//   Idle              high in IDLE
//   Done              one-cycle pulse, results valid
//   Quociente, Resto  quotient and remainder, held until the next accepted St
//   DivZero           last operation had Divisor=0
//   Overflow          last operation's quotient does not fit WIDTH bits
// Optional: define DIVISOR_EARLY_EXIT_EN to finish in one cycle when
// Dividendo < Divisor (same results, shorter latency).
module divisor
    import divisor_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 St,
    input  logic [2*WIDTH-1:0]   Dividendo,
    input  logic [WIDTH-1:0]     Divisor,
    output logic                 Idle,
    output logic                 Done,
    output logic [WIDTH-1:0]     Quociente,
    output logic [WIDTH-1:0]     Resto,
    output logic                 DivZero,
    output logic                 Overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned DW    = 2 * WIDTH;

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_div, w_div_nxt;
    logic [WIDTH-1:0]   r_rem, w_rem_nxt;
    logic [WIDTH-1:0]   r_q, w_q_nxt;
    logic [WIDTH-1:0]   r_quo, w_quo_nxt;
    logic [WIDTH-1:0]   r_res, w_res_nxt;
    logic               r_divzero, w_divzero_nxt;
    logic               r_overflow, w_overflow_nxt;
    logic               r_idle, r_done;

    logic [WIDTH-1:0]   w_hi, w_lo;
    logic [WIDTH-1:0]   w_step_r, w_step_q;

    assign w_hi = Dividendo[DW-1:WIDTH];
    assign w_lo = Dividendo[WIDTH-1:0];

    divisor_step #(.WIDTH(WIDTH)) u_step (
        .i_r       (r_rem),
        .i_q       (r_q),
        .i_divisor (r_div),
        .o_r_c     (w_step_r),
        .o_q_c     (w_step_q)
    );

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_div      <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_quo      <= '0;
            r_res      <= '0;
            r_divzero  <= 1'b0;
            r_overflow <= 1'b0;
            r_idle     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_div      <= w_div_nxt;
            r_rem      <= w_rem_nxt;
            r_q        <= w_q_nxt;
            r_quo      <= w_quo_nxt;
            r_res      <= w_res_nxt;
            r_divzero  <= w_divzero_nxt;
            r_overflow <= w_overflow_nxt;
            r_idle     <= (w_state_nxt == ST_IDLE);
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_div_nxt      = r_div;
        w_rem_nxt      = r_rem;
        w_q_nxt        = r_q;
        w_quo_nxt      = r_quo;
        w_res_nxt      = r_res;
        w_divzero_nxt  = r_divzero;
        w_overflow_nxt = r_overflow;

        unique case (r_state)
            ST_IDLE: begin
                if (St) begin
                    w_div_nxt      = Divisor;
                    w_divzero_nxt  = 1'b0;
                    w_overflow_nxt = 1'b0;
                    if (Divisor == '0) begin
                        w_state_nxt   = ST_DONE;
                        w_divzero_nxt = 1'b1;
                        w_quo_nxt     = '1;
                        w_res_nxt     = w_lo;
                    end else if (w_hi >= Divisor) begin
                        // Quotient would need more than WIDTH bits.
                        w_state_nxt    = ST_DONE;
                        w_overflow_nxt = 1'b1;
                        w_quo_nxt      = '1;
                        w_res_nxt      = w_lo;
                    end
`ifdef DIVISOR_EARLY_EXIT_EN
                    else if (Dividendo < DW'(Divisor)) begin
                        w_state_nxt = ST_DONE;
                        w_quo_nxt   = '0;
                        w_res_nxt   = w_lo;
                    end
`endif
                    else begin
                        w_state_nxt = ST_CALC;
                        w_cnt_nxt   = '0;
                        w_rem_nxt   = w_hi;
                        w_q_nxt     = w_lo;
                    end
                end
            end

            ST_CALC: begin
                w_rem_nxt = w_step_r;
                w_q_nxt   = w_step_q;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = ST_DONE;
                    w_quo_nxt   = w_step_q;
                    w_res_nxt   = w_step_r;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign Idle      = r_idle;
    assign Done      = r_done;
    assign Quociente = r_quo;
    assign Resto     = r_res;
    assign DivZero   = r_divzero;
    assign Overflow  = r_overflow;

endmodule
